// File: rtl/dmem_access_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_access_unit
// Load/store initiator between the MEM pipeline stage and a single data RAM
// port. It accepts one request at a time, checks alignment, builds byte-lane
// selects and write data for stores, and extends the selected lane for loads.
// Lane order is big-endian: byte offset 0 is bits [31:24] and sel[3].
//
// Parameters
//   WAIT_CYCLES  extra cycles the bus is held before the write/sample cycle (0..15)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   req_i        request valid (sampled while idle)
//   op_i         LB/LBU/LH/LHU/LW/SB/SH/SW opcode
//   addr_i       byte address
//   wdata_i      right-justified store data
//   flush_i      pipeline flush
//   busy_o       stall to the pipeline
//   done_o       one-cycle completion pulse
//   rdata_o      extended load result, held until the next load completes
//   exc_ade_o    one-cycle misaligned-address pulse
//   badvaddr_o   faulting address, held until the next exception
//   mem_ce_o     RAM chip enable
//   mem_we_o     RAM write enable
//   mem_sel_o    RAM byte-lane select
//   mem_addr_o   RAM word address
//   mem_data_o   RAM write data
//   mem_data_i   RAM read data (combinational from the RAM)
// -----------------------------------------------------------------------------
module dmem_access_unit #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        exc_ade_o,
    output logic [31:0] badvaddr_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LBU = 4'b0001;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LHU = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return off != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    // Loads always read the whole word; the lane is picked on the way back.
    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   return 4'b1000 >> off;
            OP_SH:   return off[1] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [3:0] op, input logic [31:0] wdata);
        case (op)
            OP_SB:   return {4{wdata[7:0]}};
            OP_SH:   return {2{wdata[15:0]}};
            OP_SW:   return wdata;
            default: return 32'd0;
        endcase
    endfunction

    // Byte at offset o lives at bit 8*(3-o); for a 2-bit offset 3-o is ~o.
    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] off,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = word[{~off, 3'b000} +: 8];
        h = off[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   r = 32'(b);
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = 32'(h);
            OP_LHU:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [3:0]  op_q;
    logic [1:0]  off_q;

    logic        ce_nxt, we_nxt, done_nxt, exc_nxt;
    logic [3:0]  sel_nxt;
    logic [31:0] maddr_nxt, mdata_nxt, rdata_nxt, bad_nxt;

    logic        req_ok, misal, accept, ade;

    assign req_ok = req_i && !flush_i && op_legal(op_i);
    assign misal  = op_misaligned(op_i, addr_i[1:0]);
    assign accept = (state == S_IDLE) && req_ok && !misal;
    assign ade    = (state == S_IDLE) && req_ok && misal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            mem_ce_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_sel_o  <= 4'd0;
            mem_addr_o <= 32'd0;
            mem_data_o <= 32'd0;
            done_o     <= 1'b0;
            exc_ade_o  <= 1'b0;
            badvaddr_o <= 32'd0;
            rdata_o    <= 32'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            mem_ce_o   <= ce_nxt;
            mem_we_o   <= we_nxt;
            mem_sel_o  <= sel_nxt;
            mem_addr_o <= maddr_nxt;
            mem_data_o <= mdata_nxt;
            done_o     <= done_nxt;
            exc_ade_o  <= exc_nxt;
            badvaddr_o <= bad_nxt;
            rdata_o    <= rdata_nxt;
        end
    end

    // Request attributes needed after the request cycle; no reset required.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_i;
            off_q <= addr_i[1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        // Bus defaults to idle; states that keep it driven say so explicitly.
        ce_nxt    = 1'b0;
        we_nxt    = 1'b0;
        sel_nxt   = 4'd0;
        maddr_nxt = 32'd0;
        mdata_nxt = 32'd0;
        done_nxt  = 1'b0;
        exc_nxt   = 1'b0;
        bad_nxt   = badvaddr_o;
        rdata_nxt = rdata_o;
        busy_o    = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    busy_o    = 1'b1;
                    ce_nxt    = 1'b1;
                    sel_nxt   = lane_sel(op_i, addr_i[1:0]);
                    maddr_nxt = {addr_i[31:2], 2'b00};
                    mdata_nxt = lane_data(op_i, wdata_i);
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end else begin
                        state_nxt = S_ACCESS;
                        we_nxt    = op_is_store(op_i);
                    end
                end else if (ade) begin
                    exc_nxt = 1'b1;
                    bad_nxt = addr_i;
                end
            end

            S_WAIT: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    // Abandoned before any write: the bus simply goes idle.
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    ce_nxt    = 1'b1;
                    sel_nxt   = mem_sel_o;
                    maddr_nxt = mem_addr_o;
                    mdata_nxt = mem_data_o;
                    if (cnt == 4'd1) begin
                        state_nxt = S_ACCESS;
                        cnt_nxt   = 4'd0;
                        we_nxt    = op_is_store(op_q);
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end

            S_ACCESS: begin
                // A store is committed at this edge regardless of flush;
                // flush only hides the completion from the pipeline.
                busy_o    = 1'b1;
                state_nxt = S_DONE;
                done_nxt  = !flush_i;
                if (!op_is_store(op_q)) begin
                    rdata_nxt = load_extend(op_q, off_q, mem_data_i);
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
`timescale 1ns/1ps
module tb_dmem_access_unit;

    localparam int W1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req;
    logic [3:0]       op_r;
    logic [31:0]      addr_r, wdata_r;
    logic             flush_r;
    logic [1:0]       busy, done, exc, mce, mwe;
    logic [1:0][31:0] rdata, bad, maddr, mdata, mrd;
    logic [1:0][3:0]  msel;

    logic [31:0] ram [2][256];
    logic        ram_init;

    // Reference model: byte-addressed big-endian memory plus held outputs.
    logic [7:0]  refm [2][1024];
    logic [31:0] exp_rdata [2];
    logic [31:0] exp_bad [2];

    int          n_pass = 0;
    int          n_total = 0;
    logic [3:0]  last_sel;
    logic [31:0] last_data;
    int          last_done_cyc;

    dmem_access_unit #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .op_i(op_r), .addr_i(addr_r),
        .wdata_i(wdata_r), .flush_i(flush_r), .busy_o(busy[0]), .done_o(done[0]),
        .rdata_o(rdata[0]), .exc_ade_o(exc[0]), .badvaddr_o(bad[0]),
        .mem_ce_o(mce[0]), .mem_we_o(mwe[0]), .mem_sel_o(msel[0]),
        .mem_addr_o(maddr[0]), .mem_data_o(mdata[0]), .mem_data_i(mrd[0])
    );

    dmem_access_unit #(.WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .op_i(op_r), .addr_i(addr_r),
        .wdata_i(wdata_r), .flush_i(flush_r), .busy_o(busy[1]), .done_o(done[1]),
        .rdata_o(rdata[1]), .exc_ade_o(exc[1]), .badvaddr_o(bad[1]),
        .mem_ce_o(mce[1]), .mem_we_o(mwe[1]), .mem_sel_o(msel[1]),
        .mem_addr_o(maddr[1]), .mem_data_o(mdata[1]), .mem_data_i(mrd[1])
    );

    function automatic logic [31:0] pat(input int d, input int i);
        return (32'(i) * 32'h9E3779B1) ^ ((d == 1) ? 32'h5A5A0000 : 32'h0000A5A5) ^ 32'h01234567;
    endfunction

    assign mrd[0] = ram[0][maddr[0][9:2]];
    assign mrd[1] = ram[1][maddr[1][9:2]];

    // RAM behaviour: commits enabled lanes at the rising edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!ram_init) begin
                for (int i = 0; i < 256; i++) ram[d][i] <= pat(d, i);
            end else if (mce[d] && mwe[d]) begin
                for (int k = 0; k < 4; k++)
                    if (msel[d][k]) ram[d][maddr[d][9:2]][8*k +: 8] <= mdata[d][8*k +: 8];
            end
        end
    end

    task automatic run_op(input int d, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input int flush_at);
        int w, sz, off, ai, exp_busy_cnt;
        int busy_cnt, done_cnt, exc_cnt, ce_cnt, we_cnt, done_cyc, exc_cyc;
        logic legal, store, aligned, accepted, misal, wflushed, acc_reached, committed, exp_done;
        logic [3:0]  esel;
        logic [31:0] edata, v;
        logic [15:0] h;
        w = (d == 1) ? W1 : 0;
        legal = 1'b1; store = 1'b0; sz = 4;
        case (op)
            4'b0000, 4'b0001: sz = 1;
            4'b0010, 4'b0011: sz = 2;
            4'b0100:          sz = 4;
            4'b1000: begin sz = 1; store = 1'b1; end
            4'b1001: begin sz = 2; store = 1'b1; end
            4'b1010: begin sz = 4; store = 1'b1; end
            default: legal = 1'b0;
        endcase
        off = int'(a[1:0]);
        ai  = int'(a[9:0]);
        aligned      = (a % 32'(sz)) == 0;
        accepted     = legal && flush_at != 0 && aligned;
        misal        = legal && flush_at != 0 && !aligned;
        wflushed     = accepted && flush_at >= 1 && flush_at <= w;
        acc_reached  = accepted && !wflushed;
        committed    = acc_reached && store;
        exp_done     = acc_reached && flush_at != w + 1;
        exp_busy_cnt = !accepted ? 0 : (wflushed ? flush_at : w + 1);
        esel = 4'b0000;
        for (int k = 0; k < 4; k++)
            if (!store || (k >= off && k < off + sz)) esel[3-k] = 1'b1;
        edata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;

        @(negedge clk);
        op_r = op; addr_r = a; wdata_r = wd; req[d] = 1'b1; flush_r = (flush_at == 0);
        #1;
        n_total++;
        if (busy[d] !== accepted) $display("FAIL busy_accept op=%h addr=%h got %b want %b", op, a, busy[d], accepted);
        else n_pass++;
        busy_cnt = 0; done_cnt = 0; exc_cnt = 0; ce_cnt = 0; we_cnt = 0; done_cyc = -1; exc_cyc = -1;
        for (int c = 1; c <= w + 5; c++) begin
            @(negedge clk);
            if (busy[d]) busy_cnt++;
            if (done[d]) begin done_cnt++; done_cyc = c; end
            if (exc[d]) begin exc_cnt++; exc_cyc = c; end
            if (mce[d]) ce_cnt++;
            if (mce[d] && mwe[d]) we_cnt++;
            if (acc_reached && c == w + 1) begin
                n_total++;
                if ({mce[d], mwe[d]} !== {1'b1, store}) $display("FAIL access_ce_we op=%h got %b want %b", op, {mce[d], mwe[d]}, {1'b1, store});
                else n_pass++;
                n_total++;
                if (msel[d] !== esel) $display("FAIL access_sel op=%h addr=%h got %b want %b", op, a, msel[d], esel);
                else n_pass++;
                n_total++;
                if (maddr[d] !== {a[31:2], 2'b00}) $display("FAIL access_addr got %h want %h", maddr[d], {a[31:2], 2'b00});
                else n_pass++;
                if (store) begin
                    n_total++;
                    if (mdata[d] !== edata) $display("FAIL access_data op=%h got %h want %h", op, mdata[d], edata);
                    else n_pass++;
                end
                last_sel = msel[d];
                last_data = mdata[d];
            end
            req[d] = 1'b0;
            flush_r = (c == flush_at);
        end
        flush_r = 1'b0;

        n_total++;
        if (busy_cnt != exp_busy_cnt) $display("FAIL busy_cycles op=%h got %0d want %0d", op, busy_cnt, exp_busy_cnt);
        else n_pass++;
        n_total++;
        if (ce_cnt != exp_busy_cnt) $display("FAIL ce_cycles op=%h got %0d want %0d", op, ce_cnt, exp_busy_cnt);
        else n_pass++;
        n_total++;
        if (we_cnt != (committed ? 1 : 0)) $display("FAIL we_cycles op=%h got %0d want %0d", op, we_cnt, committed ? 1 : 0);
        else n_pass++;
        n_total++;
        if (done_cnt != (exp_done ? 1 : 0)) $display("FAIL done_count op=%h got %0d want %0d", op, done_cnt, exp_done ? 1 : 0);
        else n_pass++;
        if (exp_done) begin
            n_total++;
            if (done_cyc != w + 2) $display("FAIL done_latency got %0d want %0d", done_cyc, w + 2);
            else n_pass++;
        end
        n_total++;
        if (exc_cnt != (misal ? 1 : 0)) $display("FAIL exc_count op=%h addr=%h got %0d want %0d", op, a, exc_cnt, misal ? 1 : 0);
        else n_pass++;
        if (misal) begin
            n_total++;
            if (exc_cyc != 1) $display("FAIL exc_cycle got %0d want 1", exc_cyc);
            else n_pass++;
            exp_bad[d] = a;
        end

        if (committed)
            for (int k = 0; k < sz; k++) refm[d][ai + k] = wd[8*(sz - 1 - k) +: 8];
        if (exp_done && !store) begin
            h = {refm[d][ai], refm[d][ai + 1]};
            case (op)
                4'b0000: v = {{24{refm[d][ai][7]}}, refm[d][ai]};
                4'b0001: v = {24'd0, refm[d][ai]};
                4'b0010: v = {{16{h[15]}}, h};
                4'b0011: v = {16'd0, h};
                default: v = {refm[d][ai], refm[d][ai + 1], refm[d][ai + 2], refm[d][ai + 3]};
            endcase
            exp_rdata[d] = v;
        end
        n_total++;
        if (rdata[d] !== exp_rdata[d]) $display("FAIL rdata op=%h addr=%h got %h want %h", op, a, rdata[d], exp_rdata[d]);
        else n_pass++;
        n_total++;
        if (bad[d] !== exp_bad[d]) $display("FAIL badvaddr got %h want %h", bad[d], exp_bad[d]);
        else n_pass++;
        last_done_cyc = done_cyc;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({busy[d], done[d], exc[d], mce[d], mwe[d]} !== 5'b0) $display("FAIL reset_ctrl dut%0d got %b want 00000", d, {busy[d], done[d], exc[d], mce[d], mwe[d]});
            else n_pass++;
            n_total++;
            if ({rdata[d], bad[d], maddr[d], mdata[d], msel[d]} !== 132'd0) $display("FAIL reset_data dut%0d got nonzero want zero", d);
            else n_pass++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy, mce, done} !== 6'b0) $display("FAIL reset_release got %b want 000000", {busy, mce, done});
        else n_pass++;
    endtask

    task automatic test_word;
        run_op(0, 4'b1010, 32'h100, 32'h11223344, -1);
        n_total++;
        if (last_sel !== 4'b1111) $display("FAIL sw_sel got %b want 1111", last_sel);
        else n_pass++;
        n_total++;
        if (last_done_cyc != 2) $display("FAIL sw_done_cycle got %0d want 2", last_done_cyc);
        else n_pass++;
        run_op(0, 4'b0100, 32'h100, 32'h0, -1);
        n_total++;
        if (rdata[0] !== 32'h11223344) $display("FAIL lw_value got %h want 11223344", rdata[0]);
        else n_pass++;
    endtask

    task automatic test_byte;
        run_op(0, 4'b1000, 32'h103, 32'h000000AA, -1);
        n_total++;
        if (last_sel !== 4'b0001) $display("FAIL sb_sel got %b want 0001", last_sel);
        else n_pass++;
        n_total++;
        if (last_data !== 32'hAAAAAAAA) $display("FAIL sb_data got %h want AAAAAAAA", last_data);
        else n_pass++;
        run_op(0, 4'b0000, 32'h103, 32'h0, -1);
        n_total++;
        if (rdata[0] !== 32'hFFFFFFAA) $display("FAIL lb_value got %h want FFFFFFAA", rdata[0]);
        else n_pass++;
        run_op(0, 4'b0001, 32'h103, 32'h0, -1);
        n_total++;
        if (rdata[0] !== 32'h000000AA) $display("FAIL lbu_value got %h want 000000AA", rdata[0]);
        else n_pass++;
    endtask

    task automatic test_half;
        run_op(0, 4'b1010, 32'h200, 32'h80017FFF, -1);
        run_op(0, 4'b0010, 32'h200, 32'h0, -1);
        n_total++;
        if (rdata[0] !== 32'hFFFF8001) $display("FAIL lh0_value got %h want FFFF8001", rdata[0]);
        else n_pass++;
        run_op(0, 4'b0011, 32'h202, 32'h0, -1);
        n_total++;
        if (rdata[0] !== 32'h00007FFF) $display("FAIL lhu2_value got %h want 00007FFF", rdata[0]);
        else n_pass++;
        run_op(0, 4'b0010, 32'h202, 32'h0, -1);
        n_total++;
        if (rdata[0] !== 32'h00007FFF) $display("FAIL lh2_value got %h want 00007FFF", rdata[0]);
        else n_pass++;
        run_op(0, 4'b1001, 32'h202, 32'h0000BEEF, -1);
        n_total++;
        if (last_sel !== 4'b0011 || last_data !== 32'hBEEFBEEF) $display("FAIL sh_lanes got %b/%h want 0011/BEEFBEEF", last_sel, last_data);
        else n_pass++;
    endtask

    task automatic test_misaligned;
        run_op(0, 4'b0100, 32'h102, 32'h0, -1);
        n_total++;
        if (bad[0] !== 32'h102) $display("FAIL ade_badvaddr got %h want 00000102", bad[0]);
        else n_pass++;
        run_op(0, 4'b1001, 32'h105, 32'h1234, -1);
        run_op(0, 4'b0101, 32'h100, 32'h0, -1);
    endtask

    task automatic test_wait;
        run_op(1, 4'b1010, 32'h300, 32'hDEADBEEF, -1);
        n_total++;
        if (last_done_cyc != 4) $display("FAIL wait_done_cycle got %0d want 4", last_done_cyc);
        else n_pass++;
        run_op(1, 4'b1010, 32'h300, 32'h12345678, 1);
        run_op(1, 4'b0100, 32'h300, 32'h0, -1);
        n_total++;
        if (rdata[1] !== 32'hDEADBEEF) $display("FAIL wait_flush_lw got %h want DEADBEEF", rdata[1]);
        else n_pass++;
    endtask

    task automatic test_flush;
        run_op(0, 4'b1010, 32'h140, 32'hCAFEF00D, 1);
        run_op(0, 4'b1010, 32'h144, 32'h0BADF00D, 0);
        run_op(0, 4'b0100, 32'h140, 32'h0, -1);
        n_total++;
        if (rdata[0] !== 32'hCAFEF00D) $display("FAIL flush_access_store got %h want CAFEF00D", rdata[0]);
        else n_pass++;
        run_op(0, 4'b0100, 32'h144, 32'h0, -1);
        run_op(1, 4'b1000, 32'h141, 32'h77, 3);
        run_op(1, 4'b0001, 32'h141, 32'h0, -1);
    endtask

    task automatic test_back_to_back;
        logic [8:0]  bm, dm, cm;
        logic [31:0] ev;
        bm = '0; dm = '0; cm = '0;
        ev = {refm[0][256], refm[0][257], refm[0][258], refm[0][259]};
        @(negedge clk);
        op_r = 4'b0100; addr_r = 32'h100; wdata_r = 32'h0; flush_r = 1'b0; req[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bm[c] = busy[0]; dm[c] = done[0]; cm[c] = mce[0];
            if (c == 5) req[0] = 1'b0;
        end
        n_total++;
        if (bm !== 9'b000011010) $display("FAIL b2b_busy got %b want 000011010", bm);
        else n_pass++;
        n_total++;
        if (dm !== 9'b000100100) $display("FAIL b2b_done got %b want 000100100", dm);
        else n_pass++;
        n_total++;
        if (cm !== 9'b000010010) $display("FAIL b2b_ce got %b want 000010010", cm);
        else n_pass++;
        exp_rdata[0] = ev;
        n_total++;
        if (rdata[0] !== exp_rdata[0]) $display("FAIL b2b_rdata got %h want %h", rdata[0], exp_rdata[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        op_r = 4'b1000; addr_r = 32'h304; wdata_r = 32'h0000005C; flush_r = 1'b0; req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        n_total++;
        if ({mce[0], mwe[0]} !== 2'b11) $display("FAIL rst_mid_access got %b want 11", {mce[0], mwe[0]});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({busy[0], done[0], exc[0], mce[0], mwe[0]} !== 5'b0) $display("FAIL rst_mid_ctrl got %b want 00000", {busy[0], done[0], exc[0], mce[0], mwe[0]});
        else n_pass++;
        n_total++;
        if ({rdata[0], bad[0], maddr[0], mdata[0], msel[0]} !== 132'd0) $display("FAIL rst_mid_data got nonzero want zero");
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin exp_rdata[d] = 32'd0; exp_bad[d] = 32'd0; end
        @(negedge clk);
        n_total++;
        if ({busy[0], mce[0]} !== 2'b00) $display("FAIL rst_mid_release got %b want 00", {busy[0], mce[0]});
        else n_pass++;
        run_op(0, 4'b0001, 32'h304, 32'h0, -1);
        run_op(0, 4'b0100, 32'h304, 32'h0, -1);
    endtask

    task automatic test_random;
        int d, w, fa, pick;
        logic [3:0]  op;
        logic [31:0] a, wd;
        for (int n = 0; n < 300; n++) begin
            d = int'($urandom_range(0, 1));
            w = (d == 1) ? W1 : 0;
            pick = int'($urandom_range(0, 9));
            case (pick)
                0: op = 4'b0000;  1: op = 4'b0001;  2: op = 4'b0010;  3: op = 4'b0011;
                4: op = 4'b0100;  5: op = 4'b1000;  6: op = 4'b1001;  7: op = 4'b1010;
                8: op = 4'b0111;  default: op = 4'b1111;
            endcase
            a = 32'($urandom_range(0, 1023));
            case ($urandom_range(0, 2))
                1: a[1:0] = 2'b00;
                2: a[0] = 1'b0;
                default: ;
            endcase
            wd = $urandom;
            fa = -1;
            if ($urandom_range(0, 4) == 0) fa = int'($urandom_range(0, w + 1));
            if (fa == w + 1 && !op[3]) fa = -1;
            run_op(d, op, a, wd, fa);
        end
    endtask

    initial begin
        logic [31:0] wv;
        rst = 1'b0; req = 2'b00; op_r = 4'd0; addr_r = 32'd0; wdata_r = 32'd0;
        flush_r = 1'b0; ram_init = 1'b0;
        last_sel = 4'd0; last_data = 32'd0; last_done_cyc = -1;
        for (int d = 0; d < 2; d++) begin
            exp_rdata[d] = 32'd0;
            exp_bad[d] = 32'd0;
            for (int i = 0; i < 1024; i++) begin
                wv = pat(d, i / 4);
                refm[d][i] = wv[8*(3 - (i % 4)) +: 8];
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        ram_init = 1'b1;
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_misaligned;
        test_wait;
        test_flush;
        test_back_to_back;
        test_reset_mid_access;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
